// File: rtl/tdm_demux_1x4.sv
// Receive end of a 4-slot TDM link: tracks slot position from a frame-sync marker
// and presents the four reassembled channels as one registered parallel word.
//
// state | meaning
// HUNT  | waiting for a sync beat; all non-sync beats are dropped
// RUN   | locked to the frame; s is the slot expected on the next beat
module tdm_demux_1x4 #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   input  logic               sync,
   output logic [4*WIDTH-1:0] o,
   output logic [1:0]         s,
   output logic               frame_valid,
   output logic               sync_err,
   output logic               locked
);

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         slot_q, slot_d;
   logic [WIDTH-1:0]   sh0_q, sh0_d;
   logic [WIDTH-1:0]   sh1_q, sh1_d;
   logic [WIDTH-1:0]   sh2_q, sh2_d;
   logic [4*WIDTH-1:0] o_q, o_d;
   logic               fv_q, fv_d;
   logic               err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         slot_q  <= 2'd0;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         o_q     <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sh0_q   <= sh0_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         o_q     <= o_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sh0_d   = sh0_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      o_d     = o_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  sh0_d   = din;
                  slot_d  = 2'd1;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (sync) begin
                  // Early sync drops the partial frame and restarts at slot 0.
                  err_d  = (slot_q != 2'd0);
                  sh0_d  = din;
                  slot_d = 2'd1;
               end else begin
                  unique case (slot_q)
                     2'd0: begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                     end
                     2'd1: begin
                        sh1_d  = din;
                        slot_d = 2'd2;
                     end
                     2'd2: begin
                        sh2_d  = din;
                        slot_d = 2'd3;
                     end
                     default: begin
                        o_d    = {din, sh2_q, sh1_q, sh0_q};
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
                     end
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   assign o           = o_q;
   assign s           = slot_q;
   assign frame_valid = fv_q;
   assign sync_err    = err_q;
   assign locked      = (state_q == RUN);

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Time-division demultiplexer: the receive end of a 4-slot serial link driven by a rotating 4x1 mux (select stepping 0,1,2,3).
- Accepts one WIDTH-bit beat per valid cycle, tracks slot position with a frame-sync marker, and reassembles four channels.
- Presents all four channels together as one registered parallel word, with a one-cycle frame_valid pulse.
- Sits on the far side of the serial channel; restores the i[3:0]-style vector that the mux serialised.

Parameters:
- WIDTH, 1, bit width of each channel and of each serial beat.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  serial beat data
- din_valid  input  1  beat qualifier; din and sync are sampled only when high
- sync  input  1  marks the beat carrying slot 0 of a frame
- o  output  4*WIDTH  reassembled frame; channel k at o[k*WIDTH +: WIDTH]
- s  output  2  slot index expected for the next beat
- frame_valid  output  1  one-cycle pulse when o is updated
- sync_err  output  1  one-cycle pulse on a framing violation
- locked  output  1  high while in RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - o=0, s=0, frame_valid=0, sync_err=0, locked=0.
  - Internal shadow slots 0..2 cleared; state=HUNT.
  - Reset asserted mid-frame discards the partial frame immediately.
- Beat definition: din_valid=1 at a rising clk edge. When din_valid=0, nothing changes except that frame_valid and sync_err return to 0.
- frame_valid and sync_err are registered and default to 0 every cycle unless set by a rule below.
- State HUNT (locked=0):
  - Beat with sync=0: ignored, s stays 0.
  - Beat with sync=1: shadow[0]<=din, s<=1, state<=RUN, locked<=1.
- State RUN (locked=1):
  - Beat with sync=0 and s in {1,2}: shadow[s]<=din, s<=s+1.
  - Beat with sync=0 and s=3:
    - o<={din, shadow[2], shadow[1], shadow[0]}, all four channels in one update.
    - frame_valid<=1; s<=0 (wrap).
  - Beat with sync=1 and s=0: expected frame start; shadow[0]<=din, s<=1.
  - Beat with sync=1 and s in {1,2,3} (early sync):
    - sync_err<=1; the partial frame is discarded and o is unchanged.
    - The beat becomes the new slot 0: shadow[0]<=din, s<=1, stay in RUN.
  - Beat with sync=0 and s=0 (missing sync):
    - sync_err<=1; the beat is discarded.
    - state<=HUNT, locked<=0, s stays 0.
- Latency: o and frame_valid change on the same edge that samples the slot-3 beat, so they are visible in the cycle after the last beat is presented.
- o holds its value between frames and is never partially updated.
- Back-to-back frames with no idle cycles are supported. frame_valid then pulses exactly once every 4 beats.
- Idle gaps (din_valid=0) may occur anywhere inside a frame. Slot position is preserved across gaps.
- sync with din_valid=0 is ignored.
- s is a free 2-bit counter that wraps 3->0 with no overflow flag.
- shadow is not cleared on wrap; it is only overwritten by new beats.

Test Plan:
- Reset, then WIDTH=1 beats 0,1,0,1 with sync on the first beat and din_valid high throughout -> o=4'b1010, a single frame_valid pulse after the 4th beat, locked=1 from the 1st beat, s sequence 1,2,3,0.
- Two back-to-back frames 1010 then 0110 (slots sent LSB first) -> o=4'b1010 then o=4'b0110, frame_valid high on exactly 2 cycles spaced 4 apart, sync_err never set.
- Frame 1010 with two din_valid=0 cycles inserted after slot 1 -> o=4'b1010, frame_valid pulses once, s held at 2 during the gap.
- Beats with no sync after reset, followed by a valid frame 1100 -> no output change while hunting; locked rises on the sync beat; o=4'b1100.
- In RUN, sync asserted on slot 2 with din=1, then 3 more beats 0,1,1 -> sync_err pulses one cycle, previous o kept until the new frame completes as o=4'b1101.
- rst_n pulled low for 1 cycle after slot 2 of a frame, then a full frame 0011 -> all outputs 0 and locked=0 during reset, HUNT resumes, then o=4'b0011.
